alu_pipe: RTL and testbench

Parametrised, registered successor of the team's 32-bit combinational ALU. It keeps the established 6-bit operation encoding and adds four things: a valid/ready handshake, registered result and status flags (Z N C V), variable-amount shifts, and an iterative multi-cycle multiplier. It sits between the operand-fetch stage and writeback of the datapath. It holds one operation in flight and one result in its output register.

---
 rtl/alu_pipe_if.sv | 25 ++
 rtl/alu_pipe.sv | 194 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake and operand/result bundle between operand fetch, alu_pipe and writeback.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [5:0]       op_code;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic             out_illegal;

    modport master (
        output in_valid, op_a, op_b, op_code, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_illegal
    );

    modport slave (
        input  in_valid, op_a, op_b, op_code, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, {Z,N,C,V} flags, variable shifts and an
// iterative shift-add multiplier (one step per cycle, WIDTH steps).
module alu_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LastCnt = SHW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
    logic [SHW-1:0]   r_cnt;
    logic             r_out_valid, r_out_illegal;
    logic [WIDTH-1:0] r_out_result;
    logic [3:0]       r_out_flags;

    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_add_v;
    logic [WIDTH:0]   w_shl, w_shr, w_sra;
    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v, w_ill, w_is_mul;
    logic [3:0]       w_flags;
    logic             w_out_free, w_in_ready, w_accept, w_mul_last, w_mul_done;
    logic [WIDTH-1:0] w_mul_sum;

    assign w_sh = bus.op_b[SHW-1:0];

    // One adder serves the whole add/sub group; subtraction is A + ~B + carry-in, so the
    // carry out is directly the "no borrow" flag.
    assign w_sum   = {1'b0, bus.op_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_add_v = (bus.op_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != bus.op_a[WIDTH-1]);

    // Extra bit on each shifter catches the last bit shifted out (0 when sh==0).
    assign w_shl = {1'b0, bus.op_a} << w_sh;
    assign w_shr = {bus.op_a, 1'b0} >> w_sh;
    assign w_sra = $signed({bus.op_a, 1'b0}) >>> w_sh;

    // Select the second adder operand and carry-in for the add/sub opcodes.
    always_comb begin
        w_add_b   = bus.op_b;
        w_add_cin = 1'b0;
        case (bus.op_code)
            6'b000010: w_add_cin = 1'b1;
            6'b000011: w_add_b   = WIDTH'(1);
            6'b000100: begin w_add_b = ~bus.op_b;        w_add_cin = 1'b1; end
            6'b000101: w_add_b   = ~bus.op_b;
            6'b000110: begin w_add_b = ~(WIDTH'(1));     w_add_cin = 1'b1; end
            default:   ;
        endcase
    end

    // Decode the single-cycle result, carry/overflow and illegal/MUL classification.
    always_comb begin
        w_res    = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_ill    = 1'b0;
        w_is_mul = 1'b0;
        case (bus.op_code)
            6'b000000, 6'b000010, 6'b000011,
            6'b000100, 6'b000101, 6'b000110: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_add_v;
            end
            6'b001001: w_res = bus.op_b;
            6'b001101, 6'b011100: begin
                w_res = {bus.op_a[WIDTH-2:0], 1'b0};
                w_c   = bus.op_a[WIDTH-1];
            end
            6'b001110: begin
                w_res = {bus.op_a[WIDTH-1], bus.op_a[WIDTH-1:1]};
                w_c   = bus.op_a[0];
            end
            6'b001111: w_res = '0;
            6'b010000: w_res = '1;
            6'b010001: w_res = bus.op_a;
            6'b010010: w_res = ~bus.op_a;
            6'b010011: w_res = bus.op_a & bus.op_b;
            6'b010100: w_res = ~bus.op_a & bus.op_b;
            6'b010101: w_res = ~(bus.op_a & bus.op_b);
            6'b010110: w_res = bus.op_a | bus.op_b;
            6'b010111: w_res = ~bus.op_a | bus.op_b;
            6'b011000: w_res = ~(bus.op_a | bus.op_b);
            6'b011001: w_res = bus.op_a ^ bus.op_b;
            6'b011010: w_res = ~bus.op_a ^ bus.op_b;
            6'b011011: w_res = ~(bus.op_a ^ bus.op_b);
            6'b011101: begin
                w_res = {1'b0, bus.op_a[WIDTH-1:1]};
                w_c   = bus.op_a[0];
            end
            6'b011110: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            6'b011111: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            6'b100001: begin
                w_res = w_sra[WIDTH:1];
                w_c   = w_sra[0];
            end
            6'b100000: begin
                if (MUL_EN) w_is_mul = 1'b1;
                else        w_ill    = 1'b1;
            end
            default:   w_ill = 1'b1;
        endcase
    end

    assign w_flags    = {(w_res == '0), w_res[WIDTH-1], w_c, w_v};
    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_in_ready = (r_state == StIdle) && w_out_free;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_mul_last = (r_state == StMul) && (r_cnt == LastCnt);
    // The final step only completes once the output register can take the product.
    assign w_mul_done = w_mul_last && w_out_free;
    assign w_mul_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    // FSM next state: enter MUL on an accepted multiply, leave once the product is stored.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept && w_is_mul) w_state_next = StMul;
            StMul:   if (w_mul_done)           w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Multiplier datapath: latch operands at accept, then one shift-add step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= bus.op_a;
            r_mplier <= bus.op_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if ((r_state == StMul) && !w_mul_last) begin
            r_acc    <= w_mul_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Output register: load a single-cycle result or the finished product, else drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_flags   <= '0;
            r_out_illegal <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= w_res;
            r_out_flags   <= w_flags;
            r_out_illegal <= w_ill;
        end else if (w_mul_done) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= w_mul_sum;
            r_out_flags   <= {(w_mul_sum == '0), w_mul_sum[WIDTH-1], 2'b00};
            r_out_illegal <= 1'b0;
        end else if (bus.out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_result  = r_out_result;
    assign bus.out_flags   = r_out_flags;
    assign bus.out_illegal = r_out_illegal;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed corner cases, multiplier timing, reset abort, a
// WIDTH=8/MUL_EN=0 build, and randomized traffic scored against a reference model.
module tb_alu_pipe;
    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  fl;
        logic        ill;
    } exp_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(32)) bus32 ();
    alu_pipe_if #(.WIDTH(8))  bus8 ();

    alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    alu_pipe #(.WIDTH(8),  .MUL_EN(1'b0)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int   n_pass = 0;
    int   n_total = 0;
    int   n_acc = 0;
    exp_t q[$];
    logic hold_pend = 1'b0;
    logic [37:0] hold_val;
    logic [5:0] ops [28] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h09, 6'h0D,
                             6'h0E, 6'h0F, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15,
                             6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D,
                             6'h1E, 6'h1F, 6'h21, 6'h20};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic ovf(input longint x);
        return (x > SMAX) || (x < SMIN);
    endfunction

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [5:0] op);
        exp_t        e;
        logic [31:0] r = '0;
        logic        c = 1'b0;
        logic        v = 1'b0;
        logic        ill = 1'b0;
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        int          sh = int'(b[4:0]);
        case (op)
            6'h00: begin r = a + b;     c = (ua + ub) > 64'hFFFFFFFF;         v = ovf(sa + sb); end
            6'h02: begin r = a + b + 1; c = (ua + ub + 64'd1) > 64'hFFFFFFFF; v = ovf(sa + sb + 1); end
            6'h03: begin r = a + 1;     c = (ua + 64'd1) > 64'hFFFFFFFF;      v = ovf(sa + 1); end
            6'h04: begin r = a - b;     c = ua >= ub;                         v = ovf(sa - sb); end
            6'h05: begin r = a - b - 1; c = ua >= ub + 64'd1;                 v = ovf(sa - sb - 1); end
            6'h06: begin r = a - 1;     c = ua >= 64'd1;                      v = ovf(sa - 1); end
            6'h09: r = b;
            6'h0D, 6'h1C: begin r = a << 1; c = a[31]; end
            6'h0E: begin r = 32'($signed(a) >>> 1); c = a[0]; end
            6'h0F: r = 32'h0;
            6'h10: r = 32'hFFFFFFFF;
            6'h11: r = a;
            6'h12: r = ~a;
            6'h13: r = a & b;
            6'h14: r = ~a & b;
            6'h15: r = ~(a & b);
            6'h16: r = a | b;
            6'h17: r = ~a | b;
            6'h18: r = ~(a | b);
            6'h19: r = a ^ b;
            6'h1A, 6'h1B: r = ~(a ^ b);
            6'h1D: begin r = a >> 1; c = a[0]; end
            6'h1E: begin r = a << sh; if (sh != 0) c = a[32 - sh]; end
            6'h1F: begin r = a >> sh; if (sh != 0) c = a[sh - 1]; end
            6'h21: begin r = 32'($signed(a) >>> sh); if (sh != 0) c = a[sh - 1]; end
            6'h20: r = 32'(ua * ub);
            default: ill = 1'b1;
        endcase
        e.res = r;
        e.fl  = {(r == 32'h0), r[31], c, v};
        e.ill = ill;
        return e;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // One cycle of scoreboarded traffic: drive at negedge, observe just after.
    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] op, input logic ordy);
        exp_t e;
        logic [37:0] cur;
        @(negedge clk);
        bus32.in_valid  = iv;
        bus32.op_a      = a;
        bus32.op_b      = b;
        bus32.op_code   = op;
        bus32.out_ready = ordy;
        #1;
        cur = {bus32.out_valid, bus32.out_result, bus32.out_flags, bus32.out_illegal};
        if (hold_pend) chk("hold_stable", cur, hold_val);
        hold_pend = bus32.out_valid && !bus32.out_ready;
        hold_val  = cur;
        if (bus32.out_valid && bus32.out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_result", bus32.out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                chk("scoreboard", {bus32.out_result, bus32.out_flags, bus32.out_illegal}, e);
            end
        end
        if (bus32.in_valid && bus32.in_ready) begin
            q.push_back(model(a, b, op));
            n_acc = n_acc + 1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() > 0; i++) step(1'b0, 32'h0, 32'h0, 6'h00, 1'b1);
        chk("drain_empty", q.size(), 0);
        hold_pend = 1'b0;
    endtask

    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] op, input logic [31:0] er, input logic [3:0] ef,
                          input logic ei);
        @(negedge clk);
        bus32.in_valid  = 1'b1;
        bus32.op_a      = a;
        bus32.op_b      = b;
        bus32.op_code   = op;
        bus32.out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, bus32.in_ready, 1'b1);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        bus32.op_a     = ~a;
        #1;
        chk({tag, "_valid"}, bus32.out_valid, 1'b1);
        chk({tag, "_result"}, bus32.out_result, er);
        chk({tag, "_flags"}, bus32.out_flags, ef);
        chk({tag, "_illegal"}, bus32.out_illegal, ei);
    endtask

    initial begin
        int seen;
        bus32.in_valid = 1'b0; bus32.op_a = '0; bus32.op_b = '0; bus32.op_code = '0;
        bus32.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.op_a = '0; bus8.op_b = '0; bus8.op_code = '0;
        bus8.out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", bus32.out_valid, 1'b0);
        chk("rst_out_result", bus32.out_result, 32'h0);
        chk("rst_out_flags", bus32.out_flags, 4'h0);
        chk("rst_out_illegal", bus32.out_illegal, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", bus32.in_ready, 1'b1);

        // WIDTH=8, MUL_EN=0 build
        @(negedge clk);
        bus8.in_valid = 1'b1; bus8.op_a = 8'h03; bus8.op_b = 8'h05; bus8.op_code = 6'b100000;
        #1 chk("w8_in_ready", bus8.in_ready, 1'b1);
        @(negedge clk);
        bus8.op_a = 8'hFF; bus8.op_b = 8'h01; bus8.op_code = 6'b000000;
        #1;
        chk("w8_mul_valid", bus8.out_valid, 1'b1);
        chk("w8_mul_illegal", bus8.out_illegal, 1'b1);
        chk("w8_mul_result", bus8.out_result, 8'h00);
        chk("w8_mul_flags", bus8.out_flags, 4'b1000);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        #1;
        chk("w8_add_result", bus8.out_result, 8'h00);
        chk("w8_add_flags", bus8.out_flags, 4'b1010);
        chk("w8_add_illegal", bus8.out_illegal, 1'b0);

        // Directed single-cycle corners
        single("add_wrap", 32'hFFFFFFFF, 32'h1, 6'b000000, 32'h0, 4'b1010, 1'b0);
        single("sub_ovf", 32'h80000000, 32'h1, 6'b000100, 32'h7FFFFFFF, 4'b0011, 1'b0);
        single("sub_borrow", 32'h0, 32'h1, 6'b000100, 32'hFFFFFFFF, 4'b0100, 1'b0);
        single("sra4", 32'h80000010, 32'h4, 6'b100001, 32'hF8000001, 4'b0100, 1'b0);
        single("shr4", 32'h80000010, 32'h4, 6'b011111, 32'h08000001, 4'b0000, 1'b0);
        single("shl31", 32'h1, 32'd31, 6'b011110, 32'h80000000, 4'b0100, 1'b0);
        single("shl1_carry", 32'hC0000000, 32'h1, 6'b011110, 32'h80000000, 4'b0110, 1'b0);
        single("sra0", 32'h80000001, 32'h20, 6'b100001, 32'h80000001, 4'b0100, 1'b0);
        single("dec_zero", 32'h0, 32'h5, 6'b000110, 32'hFFFFFFFF, 4'b0100, 1'b0);
        single("inc_ovf", 32'h7FFFFFFF, 32'h5, 6'b000011, 32'h80000000, 4'b0101, 1'b0);
        single("illegal", 32'h1234, 32'h5678, 6'b111111, 32'h0, 4'b1000, 1'b1);

        // Multiplier latency, busy handshake, then output hold
        @(negedge clk);
        bus32.in_valid = 1'b1; bus32.op_a = 32'h0000FFFF; bus32.op_b = 32'h00010001;
        bus32.op_code = 6'b100000; bus32.out_ready = 1'b1;
        #1 chk("mul_in_ready", bus32.in_ready, 1'b1);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            bus32.in_valid = 1'b0;
            bus32.op_a = $urandom;
            bus32.op_b = $urandom;
            if (j == 32) bus32.out_ready = 1'b0;
            #1;
            chk("mul_busy_valid", bus32.out_valid, 1'b0);
            chk("mul_busy_in_ready", bus32.in_ready, 1'b0);
        end
        @(negedge clk);
        #1;
        chk("mul_valid", bus32.out_valid, 1'b1);
        chk("mul_result", bus32.out_result, 32'hFFFFFFFF);
        chk("mul_flags", bus32.out_flags, 4'b0100);
        chk("mul_illegal", bus32.out_illegal, 1'b0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", bus32.out_valid, 1'b1);
            chk("hold_result", bus32.out_result, 32'hFFFFFFFF);
            chk("hold_in_ready", bus32.in_ready, 1'b0);
        end
        @(negedge clk);
        bus32.out_ready = 1'b1;
        #1 chk("release_in_ready", bus32.in_ready, 1'b1);
        @(negedge clk);
        #1 chk("release_valid", bus32.out_valid, 1'b0);

        // Back-to-back ADDs with out_ready toggling
        hold_pend = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 40 && n_acc < 8; i++)
            step(1'b1, $urandom, $urandom, 6'b000000, (i % 2) == 0);
        chk("b2b_accepted", n_acc, 8);
        drain();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else                           op = ops[$urandom_range(0, 27)];
            step($urandom_range(0, 3) != 0, rnd_operand(), rnd_operand(), op,
                 $urandom_range(0, 9) < 7);
        end
        drain();

        // Reset while a result is held
        @(negedge clk);
        bus32.in_valid = 1'b1; bus32.op_a = 32'd5; bus32.op_b = 32'd6;
        bus32.op_code = 6'b000000; bus32.out_ready = 1'b0;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        #1 chk("pre_rst_valid", bus32.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_held_valid", bus32.out_valid, 1'b0);
        chk("rst_held_result", bus32.out_result, 32'h0);
        chk("rst_held_flags", bus32.out_flags, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus32.out_ready = 1'b1;

        // Reset at MUL step 10 abandons the multiply
        @(negedge clk);
        bus32.in_valid = 1'b1; bus32.op_a = 32'h12345; bus32.op_b = 32'h6789;
        bus32.op_code = 6'b100000;
        #1 chk("abort_mul_accept", bus32.in_ready, 1'b1);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            bus32.in_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1 chk("abort_rst_valid", bus32.out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("abort_in_ready", bus32.in_ready, 1'b1);
        seen = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            #1 if (bus32.out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
